// File: rtl/mealy_seq_pkg.sv
// mealy_seq_pkg: engine state codes, scheduler states and default sizes for the sequence scheduler
package mealy_seq_pkg;
  localparam logic [2:0] S_A = 3'b000;
  localparam logic [2:0] S_B = 3'b001;
  localparam logic [2:0] S_D = 3'b011;
  localparam logic [2:0] S_F = 3'b101;
  localparam logic [2:0] S_G = 3'b110;
  localparam int N_REQ_D = 4;
  localparam int W_D = 8;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} sched_t;
endpackage

// File: rtl/mealy_seq_sched_if.sv
// mealy_seq_sched_if: requester words in, grants and collected results out
interface mealy_seq_sched_if
  import mealy_seq_pkg::*;
#(
  parameter int N_REQ = N_REQ_D,
  parameter int W = W_D,
  parameter int IDW = $clog2(N_REQ),
  parameter int CW = $clog2(W + 1)
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] data;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic               out_valid;
  logic [IDW-1:0]     out_id;
  logic [W-1:0]       out_word;
  logic [CW-1:0]      out_ones;
  modport master(output req, data, input gnt, busy, out_valid, out_id, out_word, out_ones);
  modport slave(input req, data, output gnt, busy, out_valid, out_id, out_word, out_ones);
endinterface

// File: rtl/mealy_seq_sched_engine.sv
// mealy_engine: 5-state Mealy recognizer, y combinational from (state, x), sync clear to A
module mealy_engine
  import mealy_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       x,
  output logic       y,
  output logic [2:0] state
);
  logic [2:0] w_next;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_A;
    else state <= clr ? S_A : w_next;
  always_comb begin
    w_next = S_A;
    y = 1'b0;
    case (state)
      S_A: w_next = x ? S_B : S_F;
      S_B: w_next = x ? S_A : S_D;
      S_D: begin w_next = x ? S_A : S_G; y = !x; end
      S_F: begin w_next = x ? S_B : S_F; y = 1'b1; end
      S_G: begin w_next = x ? S_D : S_G; y = x; end
      default: ;
    endcase
  end
endmodule

// File: rtl/mealy_seq_sched.sv
// mealy_seq_sched: round-robin arbiter feeding granted words serially through one Mealy engine
module mealy_seq_sched
  import mealy_seq_pkg::*;
#(
  parameter int N_REQ = N_REQ_D,
  parameter int W = W_D,
  parameter int IDW = $clog2(N_REQ),
  parameter int CW = $clog2(W + 1)
) (
  input logic clk,
  input logic rst,
  mealy_seq_sched_if.slave bus
);
  localparam int KW = $clog2(W);
  sched_t         r_state, w_next;
  logic [IDW-1:0] r_ptr, r_id, w_pick, w_idx;
  logic [W-1:0]   r_sh, r_word;
  logic [KW-1:0]  r_k;
  logic [CW-1:0]  r_ones;
  logic           w_y, w_clr;
  logic [2:0]     w_estate;
  logic [W-1:0]   w_words [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign w_words[g] = bus.data[g*W +: W];
  end
  // lowest circular offset from r_ptr wins, so scan offsets downward
  always_comb begin
    w_pick = '0;
    w_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_idx = IDW'((int'(r_ptr) + i) % N_REQ);
      if (bus.req[w_idx]) w_pick = w_idx;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = |bus.req ? LOAD : IDLE;
      LOAD: w_next = (w_estate == S_A) ? RUN : LOAD;
      RUN:  w_next = (r_k == KW'(W - 1)) ? DONE : RUN;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_id <= '0;
      r_sh <= '0;
      r_word <= '0;
      r_k <= '0;
      r_ones <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |bus.req) begin
        r_id <= w_pick;
        r_sh <= w_words[w_pick];
        r_word <= '0;
        r_k <= '0;
        r_ones <= '0;
      end
      if (r_state == RUN) begin
        r_word[r_k] <= w_y;
        r_ones <= r_ones + CW'(w_y);
        r_sh <= r_sh >> 1;
        r_k <= r_k + 1'b1;
      end
      if (r_state == DONE) r_ptr <= (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + 1'b1;
    end
  // engine only advances while bits are being shifted in
  assign w_clr = r_state != RUN;
  mealy_engine u_engine (
    .clk(clk),
    .rst(rst),
    .clr(w_clr),
    .x(r_sh[0]),
    .y(w_y),
    .state(w_estate)
  );
  assign bus.gnt = (r_state == LOAD) ? (N_REQ'(1) << r_id) : '0;
  assign bus.busy = r_state != IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.out_id = r_id;
  assign bus.out_word = r_word;
  assign bus.out_ones = r_ones;
endmodule

// File: doc/mealy_seq_sched.md
# mealy_seq_sched

Round-robin scheduler that shares one 5-state Mealy sequence engine between `N_REQ` word-level requesters. It grants one requester at a time and latches that requester's `W`-bit word. The word is fed into the engine serially, LSB first, and the engine's per-bit outputs are collected into a result word. The block sits between parallel producers and the single serial recognizer, and is the only thing that drives or resets the engine.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `W`, 8, word width in bits (2..16)
- `IDW`, `$clog2(N_REQ)`, requester index width
- `CW`, `$clog2(W+1)`, ones-count width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `req`  in  `N_REQ`  per-requester request; held until the matching `gnt` bit
- `data`  in  `N_REQ*W`  flattened words; requester i uses `data[i*W +: W]`, valid while `req[i]`
- `gnt`  out  `N_REQ`  one-hot, one-cycle grant pulse; word captured on the same edge
- `busy`  out  1  high in LOAD/RUN/DONE
- `out_valid`  out  1  one-cycle result strobe
- `out_id`  out  `IDW`  index of the requester whose result is presented
- `out_word`  out  `W`  collected engine outputs; bit k corresponds to input bit k
- `out_ones`  out  `CW`  number of 1s in `out_word`

## Operation
- The engine (`mealy_engine`) uses states A=000, B=001, D=011, F=101, G=110. Transitions are written as input x → next state / y:
  - A: 1→B/0, 0→F/0
  - B: 1→A/0, 0→D/0
  - D: 1→A/0, 0→G/1
  - F: 1→B/1, 0→F/1
  - G: 1→D/1, 0→G/0
- Any unused encoding goes to A with y=0.
- The engine has a synchronous `clr` that forces state A. The engine's y is combinational from (state, x) and is captured by the scheduler.
- Scheduler FSM states: IDLE, LOAD, RUN, DONE.
  - **IDLE:** if `req`≠0, pick the first set bit at or after `ptr`, searching circularly. On the edge: pulse `gnt[id]`, latch `data` slice into `sh`, latch `id`, assert engine `clr`, clear bit counter `k` and ones counter, and go to LOAD.
  - **LOAD:** the engine is in A and `k`=0. Go to RUN.
  - **RUN:** drive x=`sh[0]`. On each edge:
    - `out_word[k]`←y
    - ones count += y
    - `sh`>>=1
    - `k`++
  - **RUN exit:** after the edge where `k`=W-1, go to DONE.
  - **DONE:** `out_valid`=1 for this single cycle. Set `ptr`←(id+1) mod `N_REQ`, then go to IDLE.
- `out_word`, `out_id` and `out_ones` hold their values until the next job's LOAD edge.
- `req` and `data` are ignored outside IDLE. Requests not granted simply wait; none are lost.
- `req` bits that drop before being granted are not served.

## Timing
- Reset values:
  - state=IDLE, `ptr`=0
  - engine in A
  - `gnt`=0, `busy`=0, `out_valid`=0
  - `out_id`=0, `out_word`=0, `out_ones`=0
- Latency from `req` sampled in IDLE:
  - `gnt` is high in cycle +1 (LOAD).
  - RUN lasts cycles +2..+W+1.
  - `out_valid` is high in cycle +W+2.
- Throughput: one job per W+3 cycles, since IDLE always lasts at least one cycle.
- Simultaneous requests are served in round-robin order. A requester re-requesting immediately waits behind the others that are pending.
- Reset asserted mid-job aborts it immediately. No `out_valid` or `gnt` is produced, and the engine returns to A.
- The requester pointer wraps from `N_REQ`-1 to 0.

## Structure
- Package `mealy_seq_pkg` holds:
  - engine state localparams (A, B, D, F, G)
  - scheduler state enum
  - default `N_REQ`/`W`
- Sub-module `mealy_engine` has ports `clk`, `rst`, `clr`, `x`, `y`, `state`. It is the only sub-module.
- The top level contains the arbiter, shifter, counters and scheduler FSM.

## Test plan
- **All-zeros word:** `req`=0001, `data[7:0]`=8'h00 → `gnt`=0001 one cycle later; `out_valid` 10 cycles after the request is sampled, with `out_id`=0, `out_word`=8'hFE, `out_ones`=7.
- **All-ones word:** `req`=0010 with word 8'hFF → `out_id`=1, `out_word`=8'h00, `out_ones`=0.
- **Mixed word:** word 8'h04 → `out_word`=8'h16, `out_ones`=3.
- **Round-robin order:** `req`=1111 held (each requester drops its bit after its `gnt`) → grants 0,1,2,3, with `out_valid` spaced 11 cycles apart. Then re-assert `req`=1001 → grant 0, then 3.
- **Reset mid-job:** drive `rst` low during RUN bit 4 → all outputs are 0 next cycle and no `out_valid`. After release, a new request with 8'h00 still yields 8'hFE.
- **Inputs ignored while busy:** toggle `req` and `data` during RUN → the result is unaffected and `gnt` stays 0 until IDLE.
